alu_sched: RTL and testbench

Two-requester scheduler for the shared 32-bit ALU datapath (add, sub, shift-left-logical). It arbitrates round-robin between two requesters, issues one operation at a time, and runs SLL iteratively, one bit per cycle, so no barrel shifter is needed. It returns the result to the requester that issued the operation. It sits between the instruction-issue logic and the ALU.

---
 rtl/alu_sched.sv | 115 +++++++++++
 tb/tb_alu_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin scheduler in front of a shared
// ADD/SUB/SLL/PASS datapath. SLL shifts one bit per cycle from a
// down-counter, so the datapath needs no barrel shifter.
module alu_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_rs1_0,
  input  logic [WIDTH-1:0] req_rs1_1,
  input  logic [WIDTH-1:0] req_rs2_0,
  input  logic [WIDTH-1:0] req_rs2_1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_rd,
  output logic             busy
);

  // state   | meaning
  // IDLE    | arbitrating; may accept one request this cycle
  // BUSY    | operation in flight; shifting while count != 0, responding at 0
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLL  = 2'b10;

  logic [0:0]       state;
  logic             owner;
  logic             last_grant;
  logic [WIDTH-1:0] acc;
  logic [4:0]       count;

  logic             grant;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_rs1;
  logic [WIDTH-1:0] sel_rs2;

  // Round-robin grant; with no contention the lone valid requester wins.
  always_comb begin
    grant = 1'b0;
    if (req_valid0 && req_valid1) begin
      grant = ~last_grant;
    end else begin
      grant = req_valid1;
    end
    req_ready0 = (state == ST_IDLE) && req_valid0 && !grant;
    req_ready1 = (state == ST_IDLE) && req_valid1 && grant;
    accept     = req_ready0 || req_ready1;
    sel_op     = grant ? req_op1   : req_op0;
    sel_rs1    = grant ? req_rs1_1 : req_rs1_0;
    sel_rs2    = grant ? req_rs2_1 : req_rs2_0;
  end

  assign busy = (state == ST_BUSY);

  // Accept, iterate the shift, and issue the one-cycle response pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      acc        <= '0;
      count      <= '0;
      rsp_rd     <= '0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
    end else begin
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            state      <= ST_BUSY;
            count      <= 5'd0;
            case (sel_op)
              OP_ADD:  acc <= sel_rs1 + sel_rs2;
              OP_SUB:  acc <= sel_rs1 - sel_rs2;
              OP_SLL: begin
                acc   <= sel_rs1;
                count <= sel_rs2[4:0];
              end
              default: acc <= sel_rs1;
            endcase
          end
        end
        default: begin
          if (count != 5'd0) begin
            acc   <= acc << 1;
            count <= count - 5'd1;
          end else begin
            rsp_rd <= acc;
            if (owner) begin
              rsp_valid1 <= 1'b1;
            end else begin
              rsp_valid0 <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: exact-latency checks per op, round-robin
// order, back-to-back issue and reset in the middle of a shift.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic        req_ready0, req_ready1;
  logic [1:0]  req_op0 = 2'b00, req_op1 = 2'b00;
  logic [31:0] req_rs1_0 = '0, req_rs1_1 = '0, req_rs2_0 = '0, req_rs2_1 = '0;
  logic        rsp_valid0, rsp_valid1;
  logic [31:0] rsp_rd;
  logic        busy;

  int errors = 0;
  int checks = 0;

  alu_sched #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
    .req_rs2_0(req_rs2_0), .req_rs2_1(req_rs2_1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_rd(rsp_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      req_valid0 = v; req_op0 = op; req_rs1_0 = a; req_rs2_0 = b;
    end else begin
      req_valid1 = v; req_op1 = op; req_rs1_1 = a; req_rs2_1 = b;
    end
  endtask

  // Issue on requester r from the current cycle; expect busy for n+1 cycles
  // and the response exactly at k+2+n. Operands are scribbled while busy.
  task automatic do_op(input string tag, input int r, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int n);
    set_req(r, 1'b1, op, a, b);
    #1;
    chk({tag, ":ready"}, {31'd0, (r == 0) ? req_ready0 : req_ready1}, 32'd1);
    chk({tag, ":ready_excl"}, {31'd0, req_ready0 & req_ready1}, 32'd0);
    tick();
    set_req(r, 1'b0, ~op, ~a, b ^ 32'h1F);
    for (int i = 0; i <= n; i++) begin
      chk({tag, ":busy"}, {31'd0, busy}, 32'd1);
      chk({tag, ":early_rsp"}, {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
      tick();
    end
    chk({tag, ":rsp_valid"}, {30'd0, rsp_valid1, rsp_valid0}, (r == 0) ? 32'd1 : 32'd2);
    chk({tag, ":rsp_rd"}, rsp_rd, exp);
    chk({tag, ":idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic seen;

    // Reset held for two cycles.
    tick(); tick();
    chk("rst:rsp", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
    chk("rst:rd", rsp_rd, 32'd0);
    chk("rst:busy", {31'd0, busy}, 32'd0);
    chk("rst:ready", {30'd0, req_ready1, req_ready0}, 32'd0);
    reset = 1'b1;
    tick();

    do_op("add_wrap", 0, 2'b00, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    tick();
    do_op("sub_neg", 1, 2'b01, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
    tick();
    do_op("pass", 1, 2'b11, 32'h1234, 32'hDEAD, 32'h1234, 0);
    tick();
    do_op("sll3", 0, 2'b10, 32'h0000_FFFE, 32'h23, 32'h0007_FFF0, 3);
    tick();
    do_op("sll0", 1, 2'b10, 32'hABCD, 32'h20, 32'hABCD, 0);
    tick();
    do_op("sll31", 0, 2'b10, 32'h1, 32'd31, 32'h8000_0000, 31);

    // Back-to-back: valid stays high, operands change while busy; the new
    // operands are accepted in the response cycle of the first op.
    set_req(0, 1'b1, 2'b00, 32'd100, 32'd23);
    #1;
    chk("b2b:ready_a", {31'd0, req_ready0}, 32'd1);
    tick();
    set_req(0, 1'b1, 2'b00, 32'd7, 32'd8);
    #1;
    chk("b2b:busy_ready", {30'd0, busy, req_ready0}, 32'd2);
    tick();
    chk("b2b:rsp_a", {30'd0, rsp_valid1, rsp_valid0}, 32'd1);
    chk("b2b:rd_a", rsp_rd, 32'd123);
    chk("b2b:ready_same_cycle", {31'd0, req_ready0}, 32'd1);
    tick();
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
    tick();
    chk("b2b:rsp_b", {30'd0, rsp_valid1, rsp_valid0}, 32'd1);
    chk("b2b:rd_b", rsp_rd, 32'd15);

    // Round-robin after a fresh reset: requester 0 wins first.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    set_req(0, 1'b1, 2'b00, 32'd1, 32'd2);
    set_req(1, 1'b1, 2'b00, 32'd10, 32'd20);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr:ready", {30'd0, req_ready1, req_ready0}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("rr:busy_noready", {30'd0, req_ready1, req_ready0}, 32'd0);
      tick();
      chk("rr:rsp", {30'd0, rsp_valid1, rsp_valid0}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr:rd", rsp_rd, (i % 2 == 0) ? 32'd3 : 32'd30);
    end
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
    set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
    tick();
    tick();

    // Reset in the middle of a 20-bit shift: that op never responds.
    set_req(0, 1'b1, 2'b10, 32'h1, 32'd20);
    #1;
    chk("mid:ready", {31'd0, req_ready0}, 32'd1);
    tick();
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | rsp_valid0 | rsp_valid1;
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid:busy_after_rst", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 30; i++) begin
      seen = seen | rsp_valid0 | rsp_valid1 | busy;
      tick();
    end
    chk("mid:no_rsp", {31'd0, seen}, 32'd0);
    do_op("post_rst_add", 0, 2'b00, 32'd2, 32'd3, 32'd5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
